// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU.
// Contents:
//   alu_op_t - decoded operation classes produced by alu_op_decode
//   ALUOP_*  - main-decoder class codes carried on the aluop port
//   FUNC_*   - R-type function field codes recognised when aluop selects func
//   state_t  - FSM states of alu_seq_unit
package alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD,
      OP_SUB,
      OP_AND,
      OP_OR,
      OP_NOR,
      OP_SLT,
      OP_SLTU,
      OP_MULTU,
      OP_DIVU,
      OP_ILLEGAL
   } alu_op_t;

   localparam logic [1:0] ALUOP_ADD  = 2'b00;
   localparam logic [1:0] ALUOP_SUB  = 2'b01;
   localparam logic [1:0] ALUOP_FUNC = 2'b10;

   localparam logic [5:0] FUNC_ADD   = 6'b100000;
   localparam logic [5:0] FUNC_SUB   = 6'b100010;
   localparam logic [5:0] FUNC_AND   = 6'b100100;
   localparam logic [5:0] FUNC_OR    = 6'b100101;
   localparam logic [5:0] FUNC_NOR   = 6'b100111;
   localparam logic [5:0] FUNC_SLT   = 6'b101010;
   localparam logic [5:0] FUNC_SLTU  = 6'b101011;
   localparam logic [5:0] FUNC_MULTU = 6'b011001;
   localparam logic [5:0] FUNC_DIVU  = 6'b011011;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_DONE
   } state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational operation decoder for the sequential ALU.
// Ports:
//   aluop (in, 2) - main-decoder class: 00 add, 01 sub, 10 use func, 11 reserved
//   func  (in, 6) - R-type function field, only looked at when aluop = 10
//   op    (out)   - decoded operation; anything unrecognised maps to OP_ILLEGAL
module alu_op_decode
   import alu_pkg::*;
(
   input  logic [1:0] aluop,
   input  logic [5:0] func,
   output alu_op_t    op
);

   // Two-level decode: the main class first, then the function field for R-type.
   always_comb begin
      op = OP_ILLEGAL;
      case (aluop)
         ALUOP_ADD: op = OP_ADD;
         ALUOP_SUB: op = OP_SUB;
         ALUOP_FUNC: begin
            case (func)
               FUNC_ADD:   op = OP_ADD;
               FUNC_SUB:   op = OP_SUB;
               FUNC_AND:   op = OP_AND;
               FUNC_OR:    op = OP_OR;
               FUNC_NOR:   op = OP_NOR;
               FUNC_SLT:   op = OP_SLT;
               FUNC_SLTU:  op = OP_SLTU;
               FUNC_MULTU: op = OP_MULTU;
               FUNC_DIVU:  op = OP_DIVU;
               default:    op = OP_ILLEGAL;
            endcase
         end
         default: op = OP_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/alu_seq_unit.sv
// Sequential ALU: single-cycle logic/arithmetic ops plus an iterative
// shift-add unsigned multiplier and restoring unsigned divider.
// Ports:
//   clk, rst_n     - clock (rising edge) and asynchronous active-low reset
//   in_valid/ready - request handshake; ready only while idle
//   aluop, func    - operation selection (see alu_op_decode)
//   a, b           - operands, captured at accept
//   out_valid      - one-cycle pulse when result ports carry a new value
//   result         - low result, product low half, or quotient
//   result_hi      - product high half or remainder, otherwise 0
//   zero           - result == 0
//   err            - illegal op or divide by zero
// Result ports hold their value until the next out_valid pulse.
module alu_seq_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       aluop,
   input  logic [5:0]       func,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             zero,
   output logic             err
);

   alu_op_t op;
   state_t  state;

   logic [CNT_W-1:0] cnt;
   // hi_q/lo_q are the product halves while multiplying and the
   // remainder/quotient while dividing; b_q is the fixed operand.
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;
   logic [WIDTH-1:0] b_q;

   logic [WIDTH-1:0] single_res;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH-1:0] mul_hi_n;
   logic [WIDTH-1:0] mul_lo_n;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH:0]   div_diff;
   logic             div_ge;
   logic [WIDTH-1:0] div_rem_n;
   logic [WIDTH-1:0] div_quo_n;

   logic [WIDTH-1:0] done_res;
   logic [WIDTH-1:0] done_hi;
   logic             done_err;

   alu_op_decode u_decode (
      .aluop (aluop),
      .func  (func),
      .op    (op)
   );

   // Results of the ops that finish in the accept cycle, from the live operands.
   always_comb begin
      single_res = '0;
      case (op)
         OP_ADD:  single_res = a + b;
         OP_SUB:  single_res = a - b;
         OP_AND:  single_res = a & b;
         OP_OR:   single_res = a | b;
         OP_NOR:  single_res = ~(a | b);
         OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLTU: single_res = {{(WIDTH-1){1'b0}}, (a < b)};
         default: single_res = '0;
      endcase
   end

   // One shift-add multiply step: add b into the high half when the current
   // multiplier bit (lo_q[0]) is set, then shift the whole product right.
   always_comb begin
      mul_sum  = lo_q[0] ? ({1'b0, hi_q} + {1'b0, b_q}) : {1'b0, hi_q};
      mul_hi_n = mul_sum[WIDTH:1];
      mul_lo_n = {mul_sum[0], lo_q[WIDTH-1:1]};
   end

   // One restoring divide step: bring the next dividend bit into the
   // remainder and subtract b only if that does not go negative.
   always_comb begin
      div_shift = {hi_q, lo_q[WIDTH-1]};
      div_diff  = div_shift - {1'b0, b_q};
      div_ge    = (div_shift >= {1'b0, b_q});
      div_rem_n = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      div_quo_n = {lo_q[WIDTH-2:0], div_ge};
   end

   // Values loaded into the result ports on the edge that enters DONE.
   always_comb begin
      done_res = single_res;
      done_hi  = '0;
      done_err = 1'b0;
      case (state)
         S_IDLE: begin
            if (op == OP_DIVU) begin
               done_res = '1;
               done_hi  = a;
               done_err = 1'b1;
            end else if (op == OP_ILLEGAL) begin
               done_res = '0;
               done_err = 1'b1;
            end
         end
         S_MUL: begin
            done_res = mul_lo_n;
            done_hi  = mul_hi_n;
         end
         S_DIV: begin
            done_res = div_quo_n;
            done_hi  = div_rem_n;
         end
         default: ;
      endcase
   end

   // Main FSM with registered handshake and result outputs. The counter runs
   // WIDTH-1 down to 0 and the step taken while it reads 0 is the last one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         cnt       <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         b_q       <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         result    <= '0;
         result_hi <= '0;
         zero      <= 1'b1;
         err       <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid && in_ready) begin
                  b_q <= b;
                  if (op == OP_MULTU || (op == OP_DIVU && b != '0)) begin
                     state    <= (op == OP_MULTU) ? S_MUL : S_DIV;
                     cnt      <= CNT_W'(WIDTH - 1);
                     hi_q     <= '0;
                     lo_q     <= a;
                     in_ready <= 1'b0;
                  end else begin
                     state     <= S_DONE;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                     result    <= done_res;
                     result_hi <= done_hi;
                     zero      <= (done_res == '0);
                     err       <= done_err;
                  end
               end
            end
            S_MUL, S_DIV: begin
               hi_q <= (state == S_MUL) ? mul_hi_n : div_rem_n;
               lo_q <= (state == S_MUL) ? mul_lo_n : div_quo_n;
               if (cnt == '0) begin
                  state     <= S_DONE;
                  out_valid <= 1'b1;
                  result    <= done_res;
                  result_hi <= done_hi;
                  zero      <= (done_res == '0);
                  err       <= done_err;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            S_DONE: begin
               state     <= S_IDLE;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
            end
            default: begin
               state     <= S_IDLE;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed self-checking testbench for alu_seq_unit (WIDTH = 32).
// Drives requests on the falling edge and samples outputs 1 time unit after
// the rising edge; expected values are hand-computed constants.
module tb_alu_seq_unit;

   localparam int WIDTH = 32;
   localparam int LIMIT = 60;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       aluop;
   logic [5:0]       func;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] result_hi;
   logic             zero;
   logic             err;

   int testCount = 0;
   int failCount = 0;
   int lat;
   int seen;

   alu_seq_unit #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .aluop     (aluop),
      .func      (func),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .result    (result),
      .result_hi (result_hi),
      .zero      (zero),
      .err       (err)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Last-resort guard in case a wait is ever left unbounded.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Compare one observed value against its expected value.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      testCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Present one request on a falling edge once the DUT is ready, hold it
   // through the accepting rising edge, then withdraw it.
   task automatic applyStimulus(input logic [1:0] op2, input logic [5:0] fn,
                                input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!in_ready && guard < LIMIT) begin
         @(negedge clk);
         guard++;
      end
      aluop    = op2;
      func     = fn;
      a        = va;
      b        = vb;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Count cycles from accept until out_valid; optionally pokes in_valid
   // while the DUT is busy to show such requests are dropped.
   task automatic waitDone(input bit pokeBusy, output int cycles);
      cycles = 1;
      while (!out_valid && cycles < LIMIT) begin
         if (pokeBusy && cycles >= 2 && cycles <= 5) begin
            aluop    = 2'b00;
            a        = 32'd1;
            b        = 32'd1;
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         @(posedge clk);
         #1;
         cycles++;
      end
      in_valid = 1'b0;
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      aluop    = 2'b00;
      func     = 6'b000000;
      a        = '0;
      b        = '0;
      #12;
      checkOutput("rst_in_ready", in_ready, 1'b1);
      checkOutput("rst_out_valid", out_valid, 1'b0);
      checkOutput("rst_result", result, 32'h0);
      checkOutput("rst_result_hi", result_hi, 32'h0);
      checkOutput("rst_zero", zero, 1'b1);
      checkOutput("rst_err", err, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // func add 5 + 7
      applyStimulus(2'b10, 6'b100000, 32'd5, 32'd7);
      waitDone(1'b0, lat);
      checkOutput("add_latency", lat, 1);
      checkOutput("add_result", result, 32'd12);
      checkOutput("add_hi", result_hi, 32'd0);
      checkOutput("add_zero", zero, 1'b0);
      checkOutput("add_err", err, 1'b0);
      checkOutput("done_in_ready", in_ready, 1'b0);
      @(posedge clk);
      #1;
      checkOutput("pulse_one_cycle", out_valid, 1'b0);
      checkOutput("idle_in_ready", in_ready, 1'b1);
      checkOutput("hold_result", result, 32'd12);

      // aluop add wraps to zero
      applyStimulus(2'b00, 6'b000000, 32'hFFFF_FFFF, 32'd1);
      waitDone(1'b0, lat);
      checkOutput("addwrap_latency", lat, 1);
      checkOutput("addwrap_result", result, 32'h0);
      checkOutput("addwrap_zero", zero, 1'b1);

      // aluop sub goes negative
      applyStimulus(2'b01, 6'b000000, 32'd3, 32'd5);
      waitDone(1'b0, lat);
      checkOutput("sub_result", result, 32'hFFFF_FFFE);
      checkOutput("sub_zero", zero, 1'b0);

      // func sub to zero
      applyStimulus(2'b10, 6'b100010, 32'd10, 32'd10);
      waitDone(1'b0, lat);
      checkOutput("fsub_result", result, 32'h0);
      checkOutput("fsub_zero", zero, 1'b1);

      // logic ops
      applyStimulus(2'b10, 6'b100100, 32'hF0F0_1234, 32'h0FF0_FF00);
      waitDone(1'b0, lat);
      checkOutput("and_result", result, 32'h00F0_1200);
      applyStimulus(2'b10, 6'b100101, 32'hF0F0_1234, 32'h0FF0_FF00);
      waitDone(1'b0, lat);
      checkOutput("or_result", result, 32'hFFF0_FF34);
      applyStimulus(2'b10, 6'b100111, 32'hF0F0_1234, 32'h0FF0_FF00);
      waitDone(1'b0, lat);
      checkOutput("nor_result", result, 32'h000F_00CB);

      // signed vs unsigned compare: -1 < 1 signed, not unsigned
      applyStimulus(2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1);
      waitDone(1'b0, lat);
      checkOutput("slt_result", result, 32'd1);
      applyStimulus(2'b10, 6'b101011, 32'hFFFF_FFFF, 32'd1);
      waitDone(1'b0, lat);
      checkOutput("sltu_result", result, 32'd0);
      checkOutput("sltu_zero", zero, 1'b1);

      // multu with in_valid pokes while busy
      applyStimulus(2'b10, 6'b011001, 32'hFFFF_FFFF, 32'd2);
      checkOutput("mul_busy_ready", in_ready, 1'b0);
      waitDone(1'b1, lat);
      checkOutput("mul_latency", lat, 33);
      checkOutput("mul_hi", result_hi, 32'd1);
      checkOutput("mul_lo", result, 32'hFFFF_FFFE);
      checkOutput("mul_err", err, 1'b0);
      seen = 0;
      repeat (4) begin
         @(posedge clk);
         #1;
         if (out_valid) seen++;
      end
      checkOutput("mul_pokes_dropped", seen, 0);

      applyStimulus(2'b10, 6'b011001, 32'h1234_5678, 32'h0000_0100);
      waitDone(1'b0, lat);
      checkOutput("mul2_hi", result_hi, 32'h0000_0012);
      checkOutput("mul2_lo", result, 32'h3456_7800);

      // divu 100 / 7
      applyStimulus(2'b10, 6'b011011, 32'd100, 32'd7);
      waitDone(1'b0, lat);
      checkOutput("div_latency", lat, 33);
      checkOutput("div_quot", result, 32'd14);
      checkOutput("div_rem", result_hi, 32'd2);
      checkOutput("div_err", err, 1'b0);

      // divu by zero
      applyStimulus(2'b10, 6'b011011, 32'd100, 32'd0);
      waitDone(1'b0, lat);
      checkOutput("div0_latency", lat, 1);
      checkOutput("div0_result", result, 32'hFFFF_FFFF);
      checkOutput("div0_hi", result_hi, 32'd100);
      checkOutput("div0_err", err, 1'b1);
      checkOutput("div0_zero", zero, 1'b0);

      // reserved aluop
      applyStimulus(2'b11, 6'b100000, 32'd9, 32'd9);
      waitDone(1'b0, lat);
      checkOutput("ill_latency", lat, 1);
      checkOutput("ill_result", result, 32'd0);
      checkOutput("ill_hi", result_hi, 32'd0);
      checkOutput("ill_zero", zero, 1'b1);
      checkOutput("ill_err", err, 1'b1);

      // unknown func code; then a nonzero result to make the reset visible
      applyStimulus(2'b10, 6'b000000, 32'd9, 32'd9);
      waitDone(1'b0, lat);
      checkOutput("illfunc_err", err, 1'b1);
      applyStimulus(2'b10, 6'b011001, 32'd3, 32'h8000_0001);
      waitDone(1'b0, lat);
      checkOutput("mul3_hi", result_hi, 32'd1);
      checkOutput("mul3_lo", result, 32'h8000_0003);

      // reset in the middle of a multiply
      applyStimulus(2'b10, 6'b011001, 32'hFFFF_FFFF, 32'd2);
      repeat (9) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("abort_in_ready", in_ready, 1'b1);
      checkOutput("abort_out_valid", out_valid, 1'b0);
      checkOutput("abort_result", result, 32'h0);
      checkOutput("abort_hi", result_hi, 32'h0);
      checkOutput("abort_zero", zero, 1'b1);
      checkOutput("abort_err", err, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (out_valid) seen++;
      end
      checkOutput("abort_no_valid", seen, 0);

      // normal operation after the abort
      applyStimulus(2'b00, 6'b000000, 32'd3, 32'd4);
      waitDone(1'b0, lat);
      checkOutput("post_latency", lat, 1);
      checkOutput("post_result", result, 32'd7);
      checkOutput("post_err", err, 1'b0);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule

// File: doc/alu_seq_unit.md
ALU_SEQ_UNIT -- requirements
Module: alu_seq_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning datapath width in bits (legal range 8..64).
REQ-002 The block SHALL have parameter CNT_W, default $clog2(WIDTH)+1, meaning the iteration counter width.
REQ-003 Port clk  input  1  system clock, all state on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port in_valid  input  1  operation request.
REQ-006 Port in_ready  output  1  block can accept a request.
REQ-007 Port aluop  input  2  main-decoder class: 00 add, 01 sub, 10 use func, 11 reserved.
REQ-008 Port func  input  6  R-type function field.
REQ-009 Port a  input  WIDTH  operand A.
REQ-010 Port b  input  WIDTH  operand B.
REQ-011 Port out_valid  output  1  one-cycle pulse, result ports valid.
REQ-012 Port result  output  WIDTH  low result, product low half, or quotient.
REQ-013 Port result_hi  output  WIDTH  product high half or remainder, else 0.
REQ-014 Port zero  output  1  result == 0.
REQ-015 Port err  output  1  illegal op or divide-by-zero, qualified by out_valid.

Function
REQ-016 Decode SHALL be: aluop 00 add; 01 sub; 10 with func 100000 add, 100010 sub, 100100 and, 100101 or, 100111 nor, 101010 slt (signed), 101011 sltu, 011001 multu, 011011 divu; anything else illegal.
REQ-017 A request SHALL be accepted on a cycle with in_valid && in_ready; a and b, and the decoded op, are captured at accept.
REQ-018 FSM states SHALL be IDLE, MUL, DIV, DONE; in_ready = 1 only in IDLE.
REQ-019 Single-cycle ops (add/sub/and/or/nor/slt/sltu/illegal) SHALL go IDLE->DONE; out_valid asserts the cycle after accept (latency 1).
REQ-020 multu SHALL go IDLE->MUL, perform one shift-add step per cycle for exactly WIDTH cycles, then DONE; latency WIDTH+1.
REQ-021 divu SHALL go IDLE->DIV, perform one restoring step per cycle for WIDTH cycles, then DONE; latency WIDTH+1.
REQ-022 divu with b == 0 SHALL skip DIV, go straight to DONE: result = all ones, result_hi = a, err = 1; latency 1.
REQ-023 Illegal op SHALL produce result = 0, result_hi = 0, err = 1; latency 1.
REQ-024 DONE SHALL last one cycle, assert out_valid, then return to IDLE; in_ready is therefore low during DONE.
REQ-025 add/sub SHALL wrap modulo 2^WIDTH; no overflow flag.
REQ-026 result, result_hi, zero and err SHALL hold their last values until the next out_valid.
REQ-027 in_valid while in_ready = 0 SHALL be ignored and not queued.
REQ-028 The iteration counter SHALL count WIDTH-1 down to 0; the transition to DONE occurs on the cycle it reads 0.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, counter 0, in_ready 1, out_valid 0, result 0, result_hi 0, zero 1, err 0.
REQ-030 Reset during MUL or DIV SHALL abort the operation with no out_valid pulse afterwards.

Structure
REQ-031 The shared package alu_pkg SHALL hold the op enum, the func-code constants and the FSM state type.
REQ-032 Combinational decode SHALL be a sub-module alu_op_decode (aluop, func -> op enum); the FSM and datapath stay in alu_seq_unit.

Verification
REQ-033 WIDTH=32, aluop=10, func=100000, a=5, b=7 -> out_valid 1 cycle after accept, result=12, zero=0, err=0.
REQ-034 func=101010, a=0xFFFFFFFF, b=1 -> result=1; func=101011 with the same operands -> result=0.
REQ-035 func=011001, a=0xFFFFFFFF, b=2 -> out_valid 33 cycles after accept, result_hi=1, result=0xFFFFFFFE; in_valid pulses while busy are ignored.
REQ-036 func=011011, a=100, b=7 -> result=14, result_hi=2 after 33 cycles; b=0 -> result=0xFFFFFFFF, result_hi=100, err=1 after 1 cycle.
REQ-037 Start multu, drop rst_n at cycle 10 -> all outputs take their reset values at once, no out_valid; the next add request completes normally.
REQ-038 aluop=11 -> err=1, result=0, zero=1 after 1 cycle.
